// File: rtl/ex_result_stage_pkg.sv
// ex_result_stage_pkg
// Shared definitions for the ALU result stage and its condition-code register:
// ALU opcode constants, CCR bit positions, the result-stage state encoding and a
// helper that packs the four ALU flags into CCR order.
package ex_result_stage_pkg;

  // ALU opcodes
  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_XOR = 4'd4;
  localparam logic [3:0] ALU_OP_NOT = 4'd5;
  localparam logic [3:0] ALU_OP_SHL = 4'd6;
  localparam logic [3:0] ALU_OP_SHR = 4'd7;
  localparam logic [3:0] ALU_OP_CMP = 4'd8;
  localparam logic [3:0] ALU_OP_MUL = 4'd9;

  // CCR bit positions, giving the layout {OVF, CF, NF, ZF}
  localparam int CCR_ZF  = 0;
  localparam int CCR_NF  = 1;
  localparam int CCR_CF  = 2;
  localparam int CCR_OVF = 3;
  localparam int CCR_W   = 4;

  // Result-stage occupancy
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ONE    = 2'd1,
    MUL_LO = 2'd2
  } stage_state_e;

  function automatic logic [CCR_W-1:0] pack_flags(input logic zf, input logic nf,
                                                  input logic cf, input logic ovf);
    logic [CCR_W-1:0] f;
    f          = '0;
    f[CCR_ZF]  = zf;
    f[CCR_NF]  = nf;
    f[CCR_CF]  = cf;
    f[CCR_OVF] = ovf;
    return f;
  endfunction

endpackage

// File: rtl/ccr_reg.sv
// ccr_reg
// Condition-code register. Loads the ALU flags when upd_en is high, otherwise holds.
// Optional feature macro: CCR_SAVE_EN. When defined, adds a shadow register with
// save/restore controls; restore takes priority over a flag update, and a save
// captures the CCR's next value (including a same-cycle update) unless a restore
// is also requested, in which case the shadow is left unchanged.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   upd_en             load flags_in into the CCR this cycle
//   flags_in[3:0]      {OVF, CF, NF, ZF} from the ALU
//   ccr_save           (CCR_SAVE_EN) copy next CCR value into the shadow
//   ccr_restore        (CCR_SAVE_EN) load the CCR from the shadow
//   ccr[3:0]           current flag register
module ccr_reg
  import ex_result_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_en,
  input  logic [CCR_W-1:0] flags_in,
`ifdef CCR_SAVE_EN
  input  logic             ccr_save,
  input  logic             ccr_restore,
`endif
  output logic [CCR_W-1:0] ccr
);

  logic [CCR_W-1:0] ccr_q, ccr_d;
  logic [CCR_W-1:0] upd_val;

  assign upd_val = upd_en ? flags_in : ccr_q;

`ifdef CCR_SAVE_EN
  logic [CCR_W-1:0] shadow_q, shadow_d;

  always_comb begin
    ccr_d    = upd_val;
    shadow_d = shadow_q;
    if (ccr_restore) begin
      ccr_d = shadow_q;
    end else if (ccr_save) begin
      shadow_d = upd_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  always_comb begin
    ccr_d = upd_val;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q <= '0;
    end else begin
      ccr_q <= ccr_d;
    end
  end

  assign ccr = ccr_q;

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage
// Registers the ALU result toward write-back and owns the CCR. A MUL that writes the
// register file is split into two write beats (lower word, then upper word) since the
// register file has one write port. Valid/ready on both sides; flush empties the stage.
// Optional feature macro: CCR_SAVE_EN (adds ccr_save / ccr_restore and a CCR shadow).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake from the ALU
//   alu_op                     opcode (ALU_OP_MUL selects the two-beat path)
//   res_lo, res_hi             ALU result words (res_hi only used by MUL)
//   alu_zf/nf/cf/ovf, flag_we  ALU flags and CCR update enable
//   reg_we, rdst_addr, rdst_hi_addr  register write enable and destinations
//   flush                      drop any buffered beats
//   out_valid / out_ready      downstream handshake
//   out_data, out_addr, out_we write beat
//   ccr                        {OVF, CF, NF, ZF}, fed back to the ALU
module ex_result_stage
  import ex_result_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  res_lo,
  input  logic [DATA_W-1:0]  res_hi,
  input  logic               alu_zf,
  input  logic               alu_nf,
  input  logic               alu_cf,
  input  logic               alu_ovf,
  input  logic               flag_we,
  input  logic               reg_we,
  input  logic [RADDR_W-1:0] rdst_addr,
  input  logic [RADDR_W-1:0] rdst_hi_addr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [RADDR_W-1:0] out_addr,
  output logic               out_we,
`ifdef CCR_SAVE_EN
  input  logic               ccr_save,
  input  logic               ccr_restore,
`endif
  output logic [3:0]         ccr
);

  stage_state_e       state_q, state_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [RADDR_W-1:0] out_addr_q, out_addr_d;
  logic               out_we_q, out_we_d;
  logic [DATA_W-1:0]  hi_data_q, hi_data_d;
  logic [RADDR_W-1:0] hi_addr_q, hi_addr_d;

  logic accept;
  logic mul_pair;

  // A new instruction can only land when the output register is free or being
  // drained this cycle; never while the upper MUL word is still pending.
  assign in_ready  = !flush && ((state_q == EMPTY) || ((state_q == ONE) && out_ready));
  assign accept    = in_valid && in_ready;
  // A MUL that does not write the register file has no upper beat to deliver.
  assign mul_pair  = (alu_op == ALU_OP_MUL) && reg_we;
  assign out_valid = (state_q != EMPTY);

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    out_we_d   = out_we_q;
    hi_data_d  = hi_data_q;
    hi_addr_d  = hi_addr_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: ;
        ONE: begin
          if (out_ready && !accept) begin
            state_d = EMPTY;
          end
        end
        MUL_LO: begin
          if (out_ready) begin
            out_data_d = hi_data_q;
            out_addr_d = hi_addr_q;
            out_we_d   = 1'b1;
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase

      // accept only happens in EMPTY, or in ONE while the held beat drains
      if (accept) begin
        out_data_d = res_lo;
        out_addr_d = rdst_addr;
        out_we_d   = reg_we;
        if (mul_pair) begin
          hi_data_d = res_hi;
          hi_addr_d = rdst_hi_addr;
          state_d   = MUL_LO;
        end else begin
          state_d   = ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_we_q   <= 1'b0;
      hi_data_q  <= '0;
      hi_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      out_we_q   <= out_we_d;
      hi_data_q  <= hi_data_d;
      hi_addr_q  <= hi_addr_d;
    end
  end

  assign out_data = out_data_q;
  assign out_addr = out_addr_q;
  assign out_we   = out_we_q;

  ccr_reg u_ccr_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_en      (accept && flag_we),
    .flags_in    (pack_flags(alu_zf, alu_nf, alu_cf, alu_ovf)),
`ifdef CCR_SAVE_EN
    .ccr_save    (ccr_save),
    .ccr_restore (ccr_restore),
`endif
    .ccr         (ccr)
  );

endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage
// Directed, table-driven bench for ex_result_stage. Each table row is one clock cycle:
// inputs driven after the falling edge, in_ready checked before the rising edge, and the
// registered outputs checked just after it. Hand-written sequences cover reset during a
// MUL and, when CCR_SAVE_EN is defined, the CCR save/restore behaviour.
module tb_ex_result_stage;

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  fl;     // {ovf, cf, nf, zf}
    logic        fwe;
    logic        rwe;
    logic [2:0]  rd;
    logic [2:0]  rdh;
    logic        fls;
    logic        ordy;
    logic        e_irdy;
    logic        e_ovld;
    logic [15:0] e_data;
    logic [2:0]  e_addr;
    logic        e_we;
    logic [3:0]  e_ccr;
  } vec_t;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] MUL = 4'd9;
  localparam int NVEC = 18;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [15:0] res_lo;
  logic [15:0] res_hi;
  logic        alu_zf, alu_nf, alu_cf, alu_ovf;
  logic        flag_we;
  logic        reg_we;
  logic [2:0]  rdst_addr;
  logic [2:0]  rdst_hi_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_addr;
  logic        out_we;
  logic [3:0]  ccr;
`ifdef CCR_SAVE_EN
  logic        ccr_save;
  logic        ccr_restore;
`endif

  int n_tests;
  int n_fail;
  vec_t vecs [NVEC];

  ex_result_stage #(
    .DATA_W  (16),
    .RADDR_W (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .res_lo       (res_lo),
    .res_hi       (res_hi),
    .alu_zf       (alu_zf),
    .alu_nf       (alu_nf),
    .alu_cf       (alu_cf),
    .alu_ovf      (alu_ovf),
    .flag_we      (flag_we),
    .reg_we       (reg_we),
    .rdst_addr    (rdst_addr),
    .rdst_hi_addr (rdst_hi_addr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .out_we       (out_we),
`ifdef CCR_SAVE_EN
    .ccr_save     (ccr_save),
    .ccr_restore  (ccr_restore),
`endif
    .ccr          (ccr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v, input logic [3:0] op, input logic [15:0] lo, input logic [15:0] hi,
    input logic [3:0] fl, input logic fwe, input logic rwe, input logic [2:0] rd,
    input logic [2:0] rdh, input logic fls, input logic ordy, input logic e_irdy,
    input logic e_ovld, input logic [15:0] e_data, input logic [2:0] e_addr,
    input logic e_we, input logic [3:0] e_ccr);
    vec_t r;
    r.v = v; r.op = op; r.lo = lo; r.hi = hi; r.fl = fl; r.fwe = fwe; r.rwe = rwe;
    r.rd = rd; r.rdh = rdh; r.fls = fls; r.ordy = ordy; r.e_irdy = e_irdy;
    r.e_ovld = e_ovld; r.e_data = e_data; r.e_addr = e_addr; r.e_we = e_we;
    r.e_ccr = e_ccr;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    in_valid     = v.v;
    alu_op       = v.op;
    res_lo       = v.lo;
    res_hi       = v.hi;
    alu_ovf      = v.fl[3];
    alu_cf       = v.fl[2];
    alu_nf       = v.fl[1];
    alu_zf       = v.fl[0];
    flag_we      = v.fwe;
    reg_we       = v.rwe;
    rdst_addr    = v.rd;
    rdst_hi_addr = v.rdh;
    flush        = v.fls;
    out_ready    = v.ordy;
  endtask

  task automatic idle();
    drive(mk(1'b0, ADD, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1,
             1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 4'h0));
  endtask

`ifdef CCR_SAVE_EN
  // One cycle of flag traffic: an ADD with the given flags (accepted only when fwe),
  // plus save/restore controls; then check the CCR after the edge.
  task automatic ccr_step(input string name, input logic [3:0] fl, input logic fwe,
                          input logic sv, input logic rs, input logic [3:0] e_ccr);
    @(negedge clk);
    drive(mk(fwe, ADD, 16'h0, 16'h0, fl, fwe, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1,
             1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 4'h0));
    ccr_save    = sv;
    ccr_restore = rs;
    @(posedge clk);
    #1;
    check(name, {28'h0, ccr}, {28'h0, e_ccr});
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle();
`ifdef CCR_SAVE_EN
    ccr_save    = 1'b0;
    ccr_restore = 1'b0;
`endif

    //             v     op   lo        hi        fl       fwe   rwe   rd    rdh   fls   ordy
    //             irdy  ovld data      addr  we    ccr
    vecs[0]  = mk(1'b1, ADD, 16'h1234, 16'h0000, 4'b0100, 1'b1, 1'b1, 3'd2, 3'd0, 1'b0, 1'b1,
                  1'b1, 1'b1, 16'h1234, 3'd2, 1'b1, 4'b0100);
    vecs[1]  = mk(1'b1, MUL, 16'hFFFE, 16'h0001, 4'b0000, 1'b0, 1'b1, 3'd3, 3'd4, 1'b0, 1'b1,
                  1'b1, 1'b1, 16'hFFFE, 3'd3, 1'b1, 4'b0100);
    // ADD held while the upper word drains: stalled exactly one cycle
    vecs[2]  = mk(1'b1, ADD, 16'h0055, 16'h0000, 4'b0000, 1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 1'b1,
                  1'b0, 1'b1, 16'h0001, 3'd4, 1'b1, 4'b0100);
    vecs[3]  = mk(1'b1, ADD, 16'h0055, 16'h0000, 4'b0000, 1'b1, 1'b1, 3'd5, 3'd0, 1'b0, 1'b1,
                  1'b1, 1'b1, 16'h0055, 3'd5, 1'b1, 4'b0000);
    // three cycles of backpressure: outputs and CCR held
    vecs[4]  = mk(1'b1, ADD, 16'h0066, 16'h0000, 4'b1111, 1'b1, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0,
                  1'b0, 1'b1, 16'h0055, 3'd5, 1'b1, 4'b0000);
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = mk(1'b1, ADD, 16'h0066, 16'h0000, 4'b1111, 1'b1, 1'b1, 3'd6, 3'd0, 1'b0, 1'b1,
                  1'b1, 1'b1, 16'h0066, 3'd6, 1'b1, 4'b1111);
    vecs[8]  = mk(1'b1, SUB, 16'h0000, 16'h0000, 4'b0001, 1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 1'b1,
                  1'b1, 1'b1, 16'h0000, 3'd1, 1'b1, 4'b0001);
    vecs[9]  = mk(1'b1, AND, 16'h00F0, 16'h0000, 4'b1110, 1'b0, 1'b1, 3'd7, 3'd0, 1'b0, 1'b1,
                  1'b1, 1'b1, 16'h00F0, 3'd7, 1'b1, 4'b0001);
    // MUL without reg_we is a single beat
    vecs[10] = mk(1'b1, MUL, 16'h0AAA, 16'hBBBB, 4'b1110, 1'b0, 1'b0, 3'd2, 3'd5, 1'b0, 1'b1,
                  1'b1, 1'b1, 16'h0AAA, 3'd2, 1'b0, 4'b0001);
    vecs[11] = mk(1'b0, ADD, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1,
                  1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 4'b0001);
    vecs[12] = mk(1'b1, MUL, 16'h2222, 16'h1111, 4'b0010, 1'b1, 1'b1, 3'd1, 3'd6, 1'b0, 1'b0,
                  1'b1, 1'b1, 16'h2222, 3'd1, 1'b1, 4'b0010);
    // flush in MUL_LO: upper beat lost, no accept, CCR kept
    vecs[13] = mk(1'b1, ADD, 16'h0777, 16'h0000, 4'b1000, 1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 1'b1,
                  1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'b0010);
    vecs[14] = mk(1'b0, ADD, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1,
                  1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 4'b0010);
    // flush while EMPTY blocks the accept
    vecs[15] = mk(1'b1, ADD, 16'h0123, 16'h0000, 4'b1000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1,
                  1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'b0010);
    vecs[16] = mk(1'b1, ADD, 16'h0123, 16'h0000, 4'b1000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1,
                  1'b1, 1'b1, 16'h0123, 3'd0, 1'b0, 4'b1000);
    // flush of a stalled single beat
    vecs[17] = mk(1'b0, ADD, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0,
                  1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 4'b1000);

    repeat (2) @(negedge clk);
    #1;
    check("rst.out_valid", {31'h0, out_valid}, 32'h0);
    check("rst.out_data",  {16'h0, out_data},  32'h0);
    check("rst.out_addr",  {29'h0, out_addr},  32'h0);
    check("rst.out_we",    {31'h0, out_we},    32'h0);
    check("rst.ccr",       {28'h0, ccr},       32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d.in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].e_irdy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d.out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_ovld});
      check($sformatf("v%0d.ccr", i), {28'h0, ccr}, {28'h0, vecs[i].e_ccr});
      if (vecs[i].e_ovld) begin
        check($sformatf("v%0d.out_data", i), {16'h0, out_data}, {16'h0, vecs[i].e_data});
        check($sformatf("v%0d.out_addr", i), {29'h0, out_addr}, {29'h0, vecs[i].e_addr});
        check($sformatf("v%0d.out_we", i), {31'h0, out_we}, {31'h0, vecs[i].e_we});
      end
    end

    // Reset asserted while the lower MUL word is held: both beats discarded.
    @(negedge clk);
    drive(mk(1'b1, MUL, 16'h3333, 16'h4444, 4'b1010, 1'b1, 1'b1, 3'd2, 3'd3, 1'b0, 1'b0,
             1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 4'h0));
    @(posedge clk);
    #1;
    check("mulrst.lo_valid", {31'h0, out_valid}, 32'h1);
    check("mulrst.lo_data",  {16'h0, out_data},  32'h3333);
    check("mulrst.in_ready", {31'h0, in_ready},  32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check("mulrst.out_valid", {31'h0, out_valid}, 32'h0);
    check("mulrst.out_data",  {16'h0, out_data},  32'h0);
    check("mulrst.ccr",       {28'h0, ccr},       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mulrst.no_hi_beat", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("mulrst.still_empty", {31'h0, out_valid}, 32'h0);

`ifdef CCR_SAVE_EN
    ccr_step("sv.set1010",      4'b1010, 1'b1, 1'b0, 1'b0, 4'b1010);
    ccr_step("sv.save",         4'b0000, 1'b0, 1'b1, 1'b0, 4'b1010);
    ccr_step("sv.upd0001",      4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001);
    ccr_step("sv.restore",      4'b0000, 1'b0, 1'b0, 1'b1, 4'b1010);
    ccr_step("sv.upd0011",      4'b0011, 1'b1, 1'b0, 1'b0, 4'b0011);
    // restore beats both the update and the save; shadow keeps 1010
    ccr_step("sv.save_restore", 4'b0110, 1'b1, 1'b1, 1'b1, 4'b1010);
    ccr_step("sv.upd0000",      4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
    ccr_step("sv.shadow_kept",  4'b0000, 1'b0, 1'b0, 1'b1, 4'b1010);
    // save captures the same-cycle update
    ccr_step("sv.save_upd",     4'b0101, 1'b1, 1'b1, 1'b0, 4'b0101);
    ccr_step("sv.upd1111",      4'b1111, 1'b1, 1'b0, 1'b0, 4'b1111);
    ccr_step("sv.restore0101",  4'b0000, 1'b0, 1'b0, 1'b1, 4'b0101);
    @(negedge clk);
    ccr_save    = 1'b0;
    ccr_restore = 1'b0;
`endif

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
